// File: rtl/dec_scan_seq_if.sv
// Control and select bus between the scan controller and the decoder select sequencer.
interface dec_scan_seq_if;
    logic start;
    logic stop;
    logic cont;
    logic hold;
    logic A;
    logic B;
    logic C;
    logic e;
    logic busy;
    logic done;
    logic wrap;

    modport master (
        output start, stop, cont, hold,
        input  A, B, C, e, busy, done, wrap
    );

    modport slave (
        input  start, stop, cont, hold,
        output A, B, C, e, busy, done, wrap
    );
endinterface

// File: rtl/dec_scan_seq.sv
// Select sequencer for a 3-to-8 decoder: steps {A,B,C} through 0..7, holding each
// value for DWELL cycles, in single-pass or continuous mode with hold/stop control.
module dec_scan_seq #(
    parameter int DWELL = 4,
    parameter int CW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    dec_scan_seq_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CW-1:0] LAST_CNT = CW'(DWELL - 1);

    state_t        state;
    logic [2:0]    sel;
    logic [CW-1:0] cnt;
    logic          mode;
    logic          e_q;
    logic          busy_q;
    logic          done_q;
    logic          wrap_q;

    // Sequencer FSM; every output is a register so the decoder sees glitch-free selects.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            sel    <= 3'd0;
            cnt    <= '0;
            mode   <= 1'b0;
            e_q    <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            wrap_q <= 1'b0;
            case (state)
                IDLE: begin
                    sel    <= 3'd0;
                    cnt    <= '0;
                    e_q    <= 1'b0;
                    busy_q <= 1'b0;
                    if (bus.start && !bus.stop) begin
                        state  <= SCAN;
                        mode   <= bus.cont;
                        e_q    <= 1'b1;
                        busy_q <= 1'b1;
                    end
                end
                SCAN: begin
                    if (bus.stop) begin
                        state  <= IDLE;
                        sel    <= 3'd0;
                        cnt    <= '0;
                        e_q    <= 1'b0;
                        busy_q <= 1'b0;
                    end else if (bus.hold) begin
                        state <= SCAN;
                    end else if (cnt != LAST_CNT) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        cnt <= '0;
                        if (sel != 3'd7) begin
                            sel <= sel + 3'd1;
                        end else if (!mode) begin
                            state  <= DONE;
                            sel    <= 3'd0;
                            e_q    <= 1'b0;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            sel    <= 3'd0;
                            wrap_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    sel    <= 3'd0;
                    cnt    <= '0;
                    e_q    <= 1'b0;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    sel    <= 3'd0;
                    cnt    <= '0;
                    e_q    <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.A    = sel[2];
    assign bus.B    = sel[1];
    assign bus.C    = sel[0];
    assign bus.e    = e_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.wrap = wrap_q;

endmodule
